// File: rtl/activation_streamer.sv
// Frame-buffered activation streamer for the accelerator.
// Holds one n*n frame of N-bit pixels and, on start, streams it in address
// order on ce/activation, then holds ce high with zero activation until the
// pooling stage signals end_op (or DRAIN_MAX cycles elapse), then pulses done.
// Ports:
//   clk, global_rst        - clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  - frame-buffer write port (accepted in IDLE only)
//   start, pause, end_op   - stream request, stall, end-of-frame from pooling
//   ce, activation         - registered drive of the accelerator inputs
//   busy, done, timeout    - registered status
//   wr_err                 - one-cycle pulse for a dropped write
module activation_streamer #(
  parameter int unsigned n         = 10,
  parameter int unsigned N         = 16,
  parameter int unsigned AW        = 7,
  parameter int unsigned DRAIN_MAX = 256
) (
  input  logic          clk,
  input  logic          global_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          start,
  input  logic          pause,
  input  logic          end_op,
  output logic          ce,
  output logic [N-1:0]  activation,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          wr_err
);

  localparam int unsigned PIX = n * n;
  localparam int unsigned DCW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DCW-1:0]  cnt_q, cnt_d;
  logic            to_q, to_d;
  logic            ce_q, ce_d;
  logic [N-1:0]    act_q, act_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_err_q, wr_err_d;
  logic            rd_issue;
  logic            wr_ok;

  logic [N-1:0]    mem [PIX];

  // Frame buffer write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    rd_issue = 1'b0;

    // Widen by one bit so the bound check still works when 2**AW == n*n.
    wr_ok    = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < (AW + 1)'(PIX));
    wr_err_d = wr_en && !wr_ok;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          ptr_d   = '0;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      STREAM: begin
        if (!pause) begin
          rd_issue = 1'b1;
          if (ptr_q == AW'(PIX - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        // end_op wins over a simultaneous count expiry, leaving timeout clear.
        if (end_op) begin
          state_d = DONE;
        end else if (cnt_q == DCW'(DRAIN_MAX - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs land one cycle after the read issue; DRAIN flushes with zeros.
    ce_d   = rd_issue || ((state_q == DRAIN) && (state_d == DRAIN) && !pause);
    act_d  = rd_issue ? mem[ptr_q] : '0;
    busy_d = (state_d != IDLE);
    done_d = (state_q == DRAIN) && (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!global_rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      ce_q     <= 1'b0;
      act_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      ce_q     <= ce_d;
      act_q    <= act_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign ce         = ce_q;
  assign activation = act_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = to_q;
  assign wr_err     = wr_err_q;

endmodule
